divmod32_seq: RTL and testbench
===============================

Name: divmod32_seq

Overview:
- Multicycle 32-bit integer divider. It is the inverse-direction companion to the combinational add/sub datapath: it performs division by repeated trial subtraction, one restoring step per clock.
- Accepts a dividend/divisor pair through a start/busy/valid handshake and returns quotient, remainder and exception flags after a fixed latency.
- Sits beside the add/sub unit in the ALU; signed or unsigned operation is selectable per request.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- signed_op  input  1  1 = two's-complement operands, 0 = unsigned.
- dividend  input  WIDTH  numerator; latched on an accepted start.
- divisor  input  WIDTH  denominator; latched on an accepted start.
- busy  output  1  high from the cycle after accept until valid.
- valid  output  1  one-cycle pulse; results are correct in this cycle.
- quotient  output  WIDTH  held from valid until the next accept.
- remainder  output  WIDTH  held from valid until the next accept.
- div_zero  output  1  divisor was 0; held with the results.
- ovf  output  1  signed 0x80000000 / 0xFFFFFFFF; held with the results.

Behaviour:
- Reset is asynchronous on rst_n low and applies mid-operation too. Reset state: IDLE; busy = 0, valid = 0, quotient = 0, remainder = 0, div_zero = 0, ovf = 0; counter and internal registers = 0. No partial result is ever emitted after a reset.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start = 1 at edge k accepts the request.
  - Latch abs(dividend) and abs(divisor) when signed_op = 1, otherwise the raw values.
  - Latch sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend), the div_zero condition and the ovf condition.
  - Clear the partial remainder to 0 and the counter to 0. Go to CALC.
- CALC, 32 cycles, one step per cycle:
  - Shift {partial remainder, working dividend} left by 1.
  - Trial = shifted remainder − divisor, computed WIDTH+1 bits wide.
  - If there is no borrow, remainder = trial and the new quotient bit = 1; otherwise keep the shifted remainder and the quotient bit = 0.
  - The counter increments each step; after step 31 go to FIX.
- FIX, 1 cycle:
  - In signed mode, negate the quotient if sign_q = 1 and negate the remainder if sign_r = 1.
  - If div_zero: quotient = all ones and remainder = the original dividend, overriding everything else.
  - Go to DONE.
- DONE, 1 cycle: valid = 1, busy = 0, then return to IDLE.
- Latency: start sampled at edge k gives busy = 1 for cycles k+1 … k+33 and valid = 1 in cycle k+34. Latency is the same for every operand, including exceptions.
- start during CALC, FIX or DONE is ignored; there is no queuing.
- start in the same cycle that DONE returns to IDLE is accepted on the next edge; back-to-back throughput is 1 result per 35 cycles.
- Signed overflow needs no special datapath. 0x80000000 / 0xFFFFFFFF naturally yields quotient 0x80000000 and remainder 0; the only extra action is ovf = 1.
- Remainder sign follows the dividend, so the invariant dividend = quotient*divisor + remainder holds modulo 2^32 for all non-zero divisors.
- Inputs are not required to be stable after the accept edge.

Decomposition:
- Shared package divmod_pkg: FSM state encoding, WIDTH default, and the constants INT_MIN = 32'h80000000 and ALL_ONES.
- One natural sub-module: the existing addsub32 instance, used as the trial subtractor with SUB = 1. Its cout = 1 means no borrow. Only its low 32 bits feed back, with bit 32 of the shifted remainder ORed into the no-borrow decision.
- Everything else stays in divmod32_seq.

Test Plan:
- Unsigned 100 / 7 (0x64 / 0x7): valid exactly 34 cycles after start → quotient = 0x0000000E, remainder = 0x00000002, flags = 0.
- Unsigned 0xFFFFFFFF / 0x00000010 → quotient = 0x0FFFFFFF, remainder = 0x0000000F. Signed −7 / 2 (0xFFFFFFF9 / 0x2) → quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF.
- Divide by zero, 0x00001234 / 0 with either signed_op value → quotient = 0xFFFFFFFF, remainder = 0x00001234, div_zero = 1, valid at k+34.
- Signed 0x80000000 / 0xFFFFFFFF → quotient = 0x80000000, remainder = 0, ovf = 1. The same operands unsigned → quotient = 0, remainder = 0x80000000, ovf = 0.
- start re-pulsed at k+5 with different operands → ignored: exactly one valid at k+34 carrying the first request's results. start at k+35 → accepted, valid at k+69.
- rst_n driven low at k+12 for 1 cycle → busy, valid, outputs and flags = 0 immediately (no clock needed), no valid pulse afterwards; a fresh start then completes normally.

Source files
------------

// File: rtl/divmod_pkg.sv
// rtl/divmod_pkg.sv - shared FSM encoding and constants for the sequential divider
package divmod_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/addsub32.sv
// rtl/addsub32.sv - combinational add/subtract datapath, cout=1 on subtract means no borrow
module addsub32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // a + (b or ~b) + sub; on subtract the carry out is the inverted borrow
    assign {cout, sum} = {1'b0, a} + {1'b0, b ^ {WIDTH{sub}}} + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/divmod32_seq.sv
// rtl/divmod32_seq.sv - multicycle restoring divider, signed/unsigned, one step per clock
module divmod32_seq
    import divmod_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_t state, state_next;

    logic [WIDTH-1:0] rem_q;       // partial remainder
    logic [WIDTH-1:0] dvd_q;       // working dividend, quotient bits shift in at the bottom
    logic [WIDTH-1:0] dsr_q;       // magnitude of the divisor
    logic [WIDTH-1:0] orig_q;      // raw dividend, returned as remainder on divide by zero
    logic [CNT_W-1:0] cnt_q;
    logic             sgn_op_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic             dz_q;
    logic             ovf_q;

    logic [WIDTH-1:0] quo_o_q;
    logic [WIDTH-1:0] rem_o_q;
    logic             dz_o_q;
    logic             ovf_o_q;

    logic [WIDTH-1:0] trial_in;
    logic [WIDTH-1:0] trial_diff;
    logic             trial_cout;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_next;

    // Low WIDTH bits of the shifted remainder; the bit shifted out is handled separately
    assign trial_in = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};

    addsub32 #(.WIDTH(WIDTH)) u_trial_sub (
        .a    (trial_in),
        .b    (dsr_q),
        .sub  (1'b1),
        .sum  (trial_diff),
        .cout (trial_cout)
    );

    // A set bit shifted out of the remainder means the WIDTH+1 bit trial cannot borrow
    assign no_borrow = rem_q[WIDTH-1] | trial_cout;
    assign rem_next  = no_borrow ? trial_diff : trial_in;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        valid      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                busy       = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                valid      = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture, restoring iteration and final sign/exception fix-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            orig_q   <= '0;
            cnt_q    <= '0;
            sgn_op_q <= 1'b0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            quo_o_q  <= '0;
            rem_o_q  <= '0;
            dz_o_q   <= 1'b0;
            ovf_o_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        dvd_q    <= (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
                        dsr_q    <= (signed_op && divisor[WIDTH-1]) ? -divisor : divisor;
                        orig_q   <= dividend;
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        sgn_op_q <= signed_op;
                        sign_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_q <= dividend[WIDTH-1];
                        dz_q     <= (divisor == '0);
                        ovf_q    <= signed_op && (dividend == INT_MIN) && (divisor == ALL_ONES);
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_next;
                    dvd_q <= {dvd_q[WIDTH-2:0], no_borrow};
                    cnt_q <= cnt_q + CNT_ONE;
                end
                ST_FIX: begin
                    if (dz_q) begin
                        quo_o_q <= ALL_ONES;
                        rem_o_q <= orig_q;
                    end else begin
                        quo_o_q <= (sgn_op_q && sign_q_q) ? -dvd_q : dvd_q;
                        rem_o_q <= (sgn_op_q && sign_r_q) ? -rem_q : rem_q;
                    end
                    dz_o_q  <= dz_q;
                    ovf_o_q <= ovf_q;
                end
                ST_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = quo_o_q;
    assign remainder = rem_o_q;
    assign div_zero  = dz_o_q;
    assign ovf       = ovf_o_q;

endmodule

// File: tb/tb_divmod32_seq.sv
// tb/tb_divmod32_seq.sv - scoreboard bench for divmod32_seq with random and directed operands
module tb_divmod32_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        valid;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;
    logic        ovf;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          acc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   cur_acc  = -100;
    int   checks   = 0;
    int   failures = 0;

    divmod32_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic with the exceptional cases spelled out
    function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b, input int acc);
        exp_t e;
        e.acc = acc;
        e.a   = a;
        e.b   = b;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q  = 32'h8000_0000;
            e.r  = 32'd0;
            e.ov = 1'b1;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Monitor: every valid pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", {31'd0, busy}, {31'd0, (cyc >= cur_acc && cyc <= cur_acc + 32)});
            if (valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got valid=1 required no pending request (cyc %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("flags", {30'd0, div_zero, ovf}, {30'd0, e.dz, e.ov});
                    chk("latency", cyc - e.acc, 32'd33);
                end
            end
        end
    end

    // Present a request at a negedge while idle; returns the accept edge number
    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, output int acc);
        cur_acc   = cyc + 1;
        start     = 1'b1;
        signed_op = s;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        acc       = cyc;
        start     = 1'b0;
        signed_op = $urandom_range(0, 1);
        dividend  = $urandom;
        divisor   = $urandom;
        sb.push_back(model(s, a, b, acc));
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b);
        int acc;
        issue(s, a, b, acc);
        wait_to(acc + 34);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;

        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_flags", {30'd0, div_zero, ovf}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, issued back to back at the earliest idle cycle
        run_op(1'b0, 32'h0000_0064, 32'h0000_0007);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
        run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op(1'b0, 32'h0000_1234, 32'h0000_0000);
        run_op(1'b1, 32'h0000_1234, 32'h0000_0000);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
        run_op(1'b1, 32'h8000_0000, 32'h0000_0001);

        // start pulsed mid-operation must be ignored
        issue(1'b0, 32'd1000, 32'd3, acc);
        wait_to(acc + 4);
        start     = 1'b1;
        signed_op = 1'b1;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_to(acc + 34);

        // Asynchronous reset in the middle of an operation
        issue(1'b1, 32'hFFFF_F000, 32'd7, acc);
        wait_to(acc + 11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_quotient", quotient, 32'd0);
        chk("arst_remainder", remainder, 32'd0);
        chk("arst_flags", {30'd0, div_zero, ovf}, 32'd0);
        sb.delete();
        cur_acc = -100;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op(1'b1, 32'hFFFF_FF9C, 32'h0000_0007);

        // Randomised operands with a bias towards the interesting divisor ranges
        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 1);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = b >> $urandom_range(0, 31);
                3: begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : b; end
                4: b = -($urandom_range(1, 20));
                default: ;
            endcase
            run_op(s, a, b);
        end

        repeat (40) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
